// File: rtl/multi_port_address_decoder_pkg.sv
// multi_port_address_decoder_pkg: register-count, decode and rotating-priority helpers
// Shared by the decoder top, its interface users and the per-register arbiter.
package multi_port_address_decoder_pkg;
  function automatic int reg_count(input int reg_width);
    return 1 << reg_width;
  endfunction
  function automatic logic onehot_bit(input int unsigned addr, input int unsigned r);
    return addr == r;
  endfunction
  // Position of port p in the priority order that starts at ptr (0 = highest).
  function automatic int prio_pos(input int p, input int ptr, input int ports);
    return (p - ptr + ports) % ports;
  endfunction
  function automatic int ptr_width(input int ports);
    return ports > 1 ? $clog2(ports) : 1;
  endfunction
endpackage

// File: rtl/multi_port_address_decoder_if.sv
// multi_port_address_decoder_if: request/select bundle of the multi-port decoder
// In_Address/In_Enable: per-port request; Out_*: registered decode, grants and conflict stats.
interface multi_port_address_decoder_if #(
  parameter int P_RegWidth   = 3,
  parameter int P_Ports      = 2,
  parameter int P_CountWidth = 8
);
  logic [P_Ports*P_RegWidth-1:0]      In_Address;
  logic [P_Ports-1:0]                 In_Enable;
  logic [P_Ports*(2**P_RegWidth)-1:0] Out_DecodedAddress;
  logic [(2**P_RegWidth)-1:0]         Out_RegSelect;
  logic [P_Ports-1:0]                 Out_Grant;
  logic                               Out_Conflict;
  logic [P_CountWidth-1:0]            Out_ConflictCount;
  modport master (
    output In_Address, In_Enable,
    input  Out_DecodedAddress, Out_RegSelect, Out_Grant, Out_Conflict, Out_ConflictCount
  );
  modport slave (
    input  In_Address, In_Enable,
    output Out_DecodedAddress, Out_RegSelect, Out_Grant, Out_Conflict, Out_ConflictCount
  );
endinterface

// File: rtl/multi_port_address_decoder_rr_priority_select.sv
// rr_priority_select: one-hot winner among requesters, priority rotating from ptr
// req: per-port request; ptr: highest-priority port; win: one-hot winner (0 if no request).
module rr_priority_select
  import multi_port_address_decoder_pkg::*;
#(
  parameter int P_Ports = 2,
  parameter int PtrW    = ptr_width(P_Ports)
) (
  input  logic [P_Ports-1:0] req,
  input  logic [PtrW-1:0]    ptr,
  output logic [P_Ports-1:0] win
);
  // A port wins when it requests and no requester sits earlier in the rotated order.
  always_comb begin
    win = '0;
    for (int p = 0; p < P_Ports; p++) begin
      win[p] = req[p];
      for (int q = 0; q < P_Ports; q++)
        if (req[q] && prio_pos(q, int'(ptr), P_Ports) < prio_pos(p, int'(ptr), P_Ports)) win[p] = 1'b0;
    end
  end
endmodule

// File: rtl/multi_port_address_decoder.sv
// multi_port_address_decoder: registered multi-port one-hot decoder with rotating arbitration
// In_Clock/In_Reset: clock and sync active-high reset; bus: slave side of the request bundle.
module multi_port_address_decoder
  import multi_port_address_decoder_pkg::*;
#(
  parameter int P_RegWidth   = 3,
  parameter int P_Ports      = 2,
  parameter int P_CountWidth = 8
) (
  input logic In_Clock,
  input logic In_Reset,
  multi_port_address_decoder_if.slave bus
);
  localparam int NRegs = reg_count(P_RegWidth);
  localparam int PtrW  = ptr_width(P_Ports);
  logic [P_Ports-1:0]       req [NRegs];
  logic [P_Ports-1:0]       win [NRegs];
  logic [P_Ports*NRegs-1:0] dec_d, dec_q;
  logic [NRegs-1:0]         sel_d, sel_q;
  logic [P_Ports-1:0]       grant_d, grant_q;
  logic                     conflict_d, conflict_q;
  logic [P_CountWidth-1:0]  cnt_d, cnt_q;
  logic [PtrW-1:0]          ptr_d, ptr_q;
  always_comb begin
    for (int r = 0; r < NRegs; r++)
      for (int p = 0; p < P_Ports; p++)
        req[r][p] = bus.In_Enable[p] && onehot_bit(int'(bus.In_Address[p*P_RegWidth +: P_RegWidth]), r);
  end
  for (genvar r = 0; r < NRegs; r++) begin : g_arb
    rr_priority_select #(.P_Ports(P_Ports), .PtrW(PtrW)) u_sel (
      .req(req[r]),
      .ptr(ptr_q),
      .win(win[r])
    );
  end
  // Each port addresses exactly one register, so its slice is just its win bits across registers.
  always_comb begin
    grant_d = '0;
    dec_d   = '0;
    sel_d   = '0;
    for (int r = 0; r < NRegs; r++) begin
      grant_d  = grant_d | win[r];
      sel_d[r] = |win[r];
      for (int p = 0; p < P_Ports; p++)
        dec_d[p*NRegs + r] = win[r][p];
    end
    // Every register with requesters grants exactly one, so any ungranted requester means a conflict.
    conflict_d = |(bus.In_Enable & ~grant_d);
    ptr_d      = conflict_d ? (ptr_q == PtrW'(P_Ports - 1) ? '0 : ptr_q + 1'b1) : ptr_q;
    cnt_d      = (conflict_d && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_ff @(posedge In_Clock) begin
    if (In_Reset) begin
      dec_q      <= '0;
      sel_q      <= '0;
      grant_q    <= '0;
      conflict_q <= 1'b0;
      cnt_q      <= '0;
      ptr_q      <= '0;
    end else begin
      dec_q      <= dec_d;
      sel_q      <= sel_d;
      grant_q    <= grant_d;
      conflict_q <= conflict_d;
      cnt_q      <= cnt_d;
      ptr_q      <= ptr_d;
    end
  end
  assign bus.Out_DecodedAddress = dec_q;
  assign bus.Out_RegSelect      = sel_q;
  assign bus.Out_Grant          = grant_q;
  assign bus.Out_Conflict       = conflict_q;
  assign bus.Out_ConflictCount  = cnt_q;
endmodule

// File: tb/tb_multi_port_address_decoder.sv
// tb_multi_port_address_decoder: directed self-checking bench for the multi-port decoder
module tb_multi_port_address_decoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int n = 0;
  int fails = 0;
  always #5 clk = ~clk;
  multi_port_address_decoder_if #(.P_RegWidth(3), .P_Ports(2), .P_CountWidth(8)) bus_a ();
  multi_port_address_decoder_if #(.P_RegWidth(3), .P_Ports(2), .P_CountWidth(2)) bus_b ();
  multi_port_address_decoder_if #(.P_RegWidth(3), .P_Ports(4), .P_CountWidth(8)) bus_c ();
  multi_port_address_decoder #(.P_RegWidth(3), .P_Ports(2), .P_CountWidth(8)) u_a (
    .In_Clock(clk), .In_Reset(rst), .bus(bus_a)
  );
  multi_port_address_decoder #(.P_RegWidth(3), .P_Ports(2), .P_CountWidth(2)) u_b (
    .In_Clock(clk), .In_Reset(rst), .bus(bus_b)
  );
  multi_port_address_decoder #(.P_RegWidth(3), .P_Ports(4), .P_CountWidth(8)) u_c (
    .In_Clock(clk), .In_Reset(rst), .bus(bus_c)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  logic [3:0] seen;
  logic [3:0] exp_c [4];
  logic [1:0] exp_a [4];
  initial begin
    bus_a.In_Address = {3'd6, 3'd6};
    bus_a.In_Enable  = 2'b11;
    bus_b.In_Address = {3'd2, 3'd2};
    bus_b.In_Enable  = 2'b11;
    bus_c.In_Address = {4{3'd1}};
    bus_c.In_Enable  = 4'b1111;
    step();
    step();
    chk("rst_grant_a", bus_a.Out_Grant, 0);
    chk("rst_dec_a", bus_a.Out_DecodedAddress, 0);
    chk("rst_sel_a", bus_a.Out_RegSelect, 0);
    chk("rst_conf_a", bus_a.Out_Conflict, 0);
    chk("rst_cnt_a", bus_a.Out_ConflictCount, 0);
    chk("rst_grant_b", bus_b.Out_Grant, 0);
    chk("rst_grant_c", bus_c.Out_Grant, 0);
    rst = 1'b0;
    bus_b.In_Enable  = 2'b00;
    bus_c.In_Enable  = 4'b0000;
    bus_a.In_Address = {3'd5, 3'd3};
    step();
    chk("dist_grant", bus_a.Out_Grant, 2'b11);
    chk("dist_dec", bus_a.Out_DecodedAddress, 16'h2008);
    chk("dist_sel", bus_a.Out_RegSelect, 8'h28);
    chk("dist_conf", bus_a.Out_Conflict, 0);
    chk("dist_cnt", bus_a.Out_ConflictCount, 0);
    bus_a.In_Address = {3'd6, 3'd6};
    exp_a = '{2'b01, 2'b10, 2'b01, 2'b10};
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("conf_grant_%0d", i), bus_a.Out_Grant, exp_a[i]);
      chk($sformatf("conf_dec_%0d", i), bus_a.Out_DecodedAddress, exp_a[i] == 2'b01 ? 16'h0040 : 16'h4000);
      chk($sformatf("conf_sel_%0d", i), bus_a.Out_RegSelect, 8'h40);
      chk($sformatf("conf_pulse_%0d", i), bus_a.Out_Conflict, 1);
      chk($sformatf("conf_cnt_%0d", i), bus_a.Out_ConflictCount, i + 1);
    end
    bus_a.In_Enable = 2'b00;
    step();
    chk("idle_grant", bus_a.Out_Grant, 0);
    chk("idle_conf", bus_a.Out_Conflict, 0);
    chk("idle_cnt_hold", bus_a.Out_ConflictCount, 4);
    chk("idle_sel", bus_a.Out_RegSelect, 0);
    bus_b.In_Enable = 2'b11;
    for (int i = 0; i < 5; i++) begin
      step();
      chk($sformatf("sat_cnt_%0d", i), bus_b.Out_ConflictCount, i < 3 ? i + 1 : 3);
      chk($sformatf("sat_grant_%0d", i), bus_b.Out_Grant, i % 2 == 0 ? 2'b01 : 2'b10);
    end
    bus_b.In_Enable = 2'b00;
    bus_c.In_Enable = 4'b1111;
    seen = '0;
    exp_c = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("p4_grant_%0d", i), bus_c.Out_Grant, exp_c[i]);
      chk($sformatf("p4_sel_%0d", i), bus_c.Out_RegSelect, 8'h02);
      seen = seen | bus_c.Out_Grant;
    end
    chk("p4_all_seen", seen, 4'b1111);
    bus_c.In_Enable = 4'b1011;
    exp_c = '{4'b0001, 4'b0010, 4'b1000, 4'b1000};
    for (int i = 0; i < 4; i++) begin
      step();
      chk($sformatf("p4_dis_grant_%0d", i), bus_c.Out_Grant, exp_c[i]);
      chk($sformatf("p4_dis_slice2_%0d", i), bus_c.Out_DecodedAddress[23:16], 0);
    end
    bus_c.In_Enable = 4'b0000;
    bus_a.In_Enable = 2'b11;
    step();
    chk("mid_grant0", bus_a.Out_Grant, 2'b01);
    step();
    chk("mid_grant1", bus_a.Out_Grant, 2'b10);
    step();
    chk("mid_grant2", bus_a.Out_Grant, 2'b01);
    rst = 1'b1;
    step();
    chk("mid_rst_grant", bus_a.Out_Grant, 0);
    chk("mid_rst_conf", bus_a.Out_Conflict, 0);
    chk("mid_rst_cnt", bus_a.Out_ConflictCount, 0);
    chk("mid_rst_sel", bus_a.Out_RegSelect, 0);
    rst = 1'b0;
    step();
    chk("post_rst_grant", bus_a.Out_Grant, 2'b01);
    chk("post_rst_conf", bus_a.Out_Conflict, 1);
    chk("post_rst_cnt", bus_a.Out_ConflictCount, 1);
    $display("[TB] %0d tests run, %0d failed", n, fails);
    $finish;
  end
endmodule
